// File: rtl/inst_queue.sv
// inst_queue: {pc, inst} circular FIFO between fetch and decode with flush.
// Define IQ_BYPASS_EN for a same-cycle bypass from in_* to out_* when the queue is empty.
module inst_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_inst,
   output logic [PTR_W:0]   count
);
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
   logic [XLEN-1:0]  mem_pc   [DEPTH];
   logic [XLEN-1:0]  mem_inst [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic empty, push, pop, byp, wr, rd;
   always_comb begin
      empty     = count == '0;
      in_ready  = (count != FULL) & ~flush;
      push      = in_valid & in_ready;
`ifdef IQ_BYPASS_EN
      byp       = empty & in_valid & ~flush;
`else
      byp       = 1'b0;
`endif
      out_valid = (~empty | byp) & ~flush;
      pop       = out_valid & out_ready;
      // a bypassed pair that decode takes immediately is never stored
      wr        = push & ~(byp & out_ready);
      rd        = pop & ~byp;
      out_pc    = byp ? in_pc   : empty ? '0 : mem_pc[rd_ptr];
      out_inst  = byp ? in_inst : empty ? '0 : mem_inst[rd_ptr];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         if (wr & ~rd) count <= count + 1'b1;
         else if (rd & ~wr) count <= count - 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_pc[wr_ptr]   <= in_pc;
         mem_inst[wr_ptr] <= in_inst;
      end
   end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: scoreboard bench for inst_queue; honours IQ_BYPASS_EN if defined.
module tb_inst_queue;
   logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_pc = 0, in_inst = 0;
   logic in_ready, out_valid;
   logic [31:0] out_pc, out_inst;
   logic [2:0] count;
   typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
   ent_t sb[$];
   int total = 0, bad = 0, exp_cnt = 0;

   inst_queue #(.XLEN(32), .DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {16'h0093, pc[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // monitor: every consumed head entry must match the scoreboard front
   always @(negedge clk) begin
      ent_t e;
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got pc %h want none", out_pc);
         end else begin
            e = sb.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_inst", out_inst, e.inst);
         end
      end
   end

   task automatic cyc(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
      logic acc, byp, pp;
      in_valid = iv; in_pc = pc; in_inst = inst_of(pc); out_ready = ordy; flush = fl;
      acc = iv && exp_cnt != 4 && !fl;
`ifdef IQ_BYPASS_EN
      byp = iv && exp_cnt == 0 && !fl;
`else
      byp = 1'b0;
`endif
      pp = (exp_cnt != 0 || byp) && ordy && !fl;
      if (fl) sb.delete();
      if (acc) sb.push_back({pc, inst_of(pc)});
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_cnt != 4 && !fl});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (exp_cnt != 0 || byp) && !fl});
      exp_cnt = fl ? 0 : exp_cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
      @(posedge clk); #1;
      chk("count", {29'd0, count}, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // reset with randomised data inputs
      for (int i = 0; i < 3; i++) begin
         in_pc = $urandom; in_inst = $urandom; out_ready = 1'($urandom);
         @(posedge clk); #1;
         chk("rst_count", {29'd0, count}, 0);
         chk("rst_out_valid", {31'd0, out_valid}, 0);
         chk("rst_in_ready", {31'd0, in_ready}, 1);
      end
      rst = 1; out_ready = 0;
      @(posedge clk); #1;
      chk("rel_count", {29'd0, count}, 0);
      chk("rel_out_valid", {31'd0, out_valid}, 0);
      // fill then drain
      for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 0, 0);
      chk("full_count", {29'd0, count}, 4);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
      // streaming at depth 2 across pointer wrap
      cyc(1, 32'h100, 0, 0);
      cyc(1, 32'h104, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 32'(i * 4), 1, 0);
      chk("stream_count", {29'd0, count}, 2);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      // full with simultaneous push attempt and pop
      for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 32'(i * 4), 0, 0);
      cyc(1, 32'h210, 1, 0);
      chk("fullsim_count", {29'd0, count}, 3);
      // flush with a coinciding fetch
      cyc(1, 32'h300, 0, 1);
      chk("flush_count", {29'd0, count}, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(1, 32'h304, 0, 0);
      cyc(0, 0, 1, 0);
      // empty-queue latency
      in_valid = 1; in_pc = 32'h40; in_inst = inst_of(32'h40); out_ready = 1; flush = 0;
      sb.push_back({32'h40, inst_of(32'h40)});
      #1;
`ifdef IQ_BYPASS_EN
      chk("byp_out_valid", {31'd0, out_valid}, 1);
      chk("byp_out_pc", out_pc, 32'h40);
      @(posedge clk); #1;
      in_valid = 0;
      chk("byp_count", {29'd0, count}, 0);
`else
      chk("nobyp_out_valid", {31'd0, out_valid}, 0);
      chk("nobyp_out_pc", out_pc, 32'h0);
      @(posedge clk); #1;
      in_valid = 0;
      chk("nobyp_count", {29'd0, count}, 1);
      chk("nobyp_out_pc_next", out_pc, 32'h40);
      @(posedge clk); #1;
      chk("nobyp_count_after", {29'd0, count}, 0);
`endif
      exp_cnt = 0;
      // asynchronous reset mid-operation
      cyc(1, 32'h500, 0, 0);
      cyc(1, 32'h504, 0, 0);
      in_valid = 0;
      #2;
      rst = 0;
      #1;
      chk("arst_count", {29'd0, count}, 0);
      chk("arst_out_valid", {31'd0, out_valid}, 0);
      chk("arst_in_ready", {31'd0, in_ready}, 1);
      sb.delete();
      exp_cnt = 0;
      rst = 1;
      @(posedge clk); #1;
      cyc(1, 32'h600, 0, 0);
      cyc(0, 0, 1, 0);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
